// File: rtl/caliptra_ss_lc_pwr_seq.sv
// Power-manager sequencer for the LC controller: settle delay, init request, done tracking, re-init reset pulse.
// Optional INIT timeout (ERR state) enabled by defining CALIPTRA_SS_LC_PWR_SEQ_TIMEOUT_EN.

package pwrmgr_pkg;
    typedef struct packed {
        logic caliptra_ss_lc_init;
    } pwr_caliptra_ss_lc_req_t;

    typedef struct packed {
        logic caliptra_ss_lc_done;
    } pwr_caliptra_ss_lc_rsp_t;
endpackage

module caliptra_ss_lc_pwr_seq #(
    parameter int INIT_DELAY   = 500,
    parameter int RST_HOLD     = 20,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cptra_pwrgood,
    input  logic                                reinit_req_i,
    output pwrmgr_pkg::pwr_caliptra_ss_lc_req_t pwr_caliptra_ss_lc_i,
    input  pwrmgr_pkg::pwr_caliptra_ss_lc_rsp_t pwr_caliptra_ss_lc_o,
    output logic                                lc_rst_n_o,
    output logic                                init_done_o,
    output logic                                init_err_o,
    output logic                                busy_o
);

`ifdef CALIPTRA_SS_LC_PWR_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    // DONE_TIMEOUT only sizes the counter when the timeout is built in.
    localparam int MAX_DR  = (INIT_DELAY > RST_HOLD) ? INIT_DELAY : RST_HOLD;
    localparam int MAX_TO  = TIMEOUT_EN ? DONE_TIMEOUT : 1;
    localparam int CNT_MAX = (MAX_DR > MAX_TO) ? MAX_DR : MAX_TO;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_INIT    = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_RSTHOLD = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lc_done;
    logic             init_q;
    logic             err_q;

    assign lc_done = pwr_caliptra_ss_lc_o.caliptra_ss_lc_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cptra_pwrgood) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(INIT_DELAY - 1)) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (lc_done) begin
                    state_d = ST_DONE;
                end
`ifdef CALIPTRA_SS_LC_PWR_SEQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end
`endif
            end
            ST_DONE: begin
                if (reinit_req_i) state_d = ST_RSTHOLD;
            end
            ST_RSTHOLD: begin
                if (cnt_q == CNT_W'(RST_HOLD - 1)) state_d = ST_SETTLE;
            end
            ST_ERR: begin
                if (reinit_req_i) state_d = ST_RSTHOLD;
            end
            default: state_d = ST_IDLE;
        endcase
        // Power-good loss beats every other transition, including a re-init.
        if (!cptra_pwrgood) state_d = ST_IDLE;
    end

    // Only counting states advance the counter, so each compare terminates it before wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_SETTLE || state_q == ST_RSTHOLD ||
                     (TIMEOUT_EN && state_q == ST_INIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are flopped from the next-state decode so they align with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lc_rst_n_o  <= 1'b0;
            init_q      <= 1'b0;
            init_done_o <= 1'b0;
            err_q       <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lc_rst_n_o  <= (state_d == ST_SETTLE) || (state_d == ST_INIT) ||
                           (state_d == ST_DONE)   || (state_d == ST_ERR);
            init_q      <= (state_d == ST_INIT) || (state_d == ST_DONE) || (state_d == ST_ERR);
            init_done_o <= (state_d == ST_DONE);
            err_q       <= TIMEOUT_EN && (state_d == ST_ERR);
            busy_o      <= (state_d == ST_SETTLE) || (state_d == ST_INIT) ||
                           (state_d == ST_RSTHOLD);
        end
    end

    assign init_err_o = err_q;

    always_comb begin
        pwr_caliptra_ss_lc_i                     = '0;
        pwr_caliptra_ss_lc_i.caliptra_ss_lc_init = init_q;
    end

endmodule

// File: tb/tb_caliptra_ss_lc_pwr_seq.sv
// Directed bench for caliptra_ss_lc_pwr_seq: power-up, done, re-init, timeout, power-good drop, async reset.
// Timeout steps follow CALIPTRA_SS_LC_PWR_SEQ_TIMEOUT_EN; otherwise INIT must wait indefinitely.

module tb_caliptra_ss_lc_pwr_seq;

    localparam int INIT_DELAY   = 500;
    localparam int RST_HOLD     = 20;
    localparam int DONE_TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    logic cptra_pwrgood;
    logic reinit_req_i;
    pwrmgr_pkg::pwr_caliptra_ss_lc_req_t pwr_caliptra_ss_lc_i;
    pwrmgr_pkg::pwr_caliptra_ss_lc_rsp_t pwr_caliptra_ss_lc_o;
    logic lc_rst_n_o;
    logic init_done_o;
    logic init_err_o;
    logic busy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    caliptra_ss_lc_pwr_seq #(
        .INIT_DELAY  (INIT_DELAY),
        .RST_HOLD    (RST_HOLD),
        .DONE_TIMEOUT(DONE_TIMEOUT)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .cptra_pwrgood       (cptra_pwrgood),
        .reinit_req_i        (reinit_req_i),
        .pwr_caliptra_ss_lc_i(pwr_caliptra_ss_lc_i),
        .pwr_caliptra_ss_lc_o(pwr_caliptra_ss_lc_o),
        .lc_rst_n_o          (lc_rst_n_o),
        .init_done_o         (init_done_o),
        .init_err_o          (init_err_o),
        .busy_o              (busy_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Full output vector: lc_rst_n, init, done, err, busy.
    task automatic check_all(input string tag, input logic [4:0] exp);
        check({tag, ".lc_rst_n"}, lc_rst_n_o, exp[4]);
        check({tag, ".init"}, pwr_caliptra_ss_lc_i.caliptra_ss_lc_init, exp[3]);
        check({tag, ".done"}, init_done_o, exp[2]);
        check({tag, ".err"}, init_err_o, exp[1]);
        check({tag, ".busy"}, busy_o, exp[0]);
    endtask

    task automatic pulse_reinit();
        reinit_req_i = 1'b1;
        step();
        reinit_req_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cptra_pwrgood = 1'b0;
        reinit_req_i = 1'b0;
        pwr_caliptra_ss_lc_o = '0;
        steps(3);
        check_all("reset", 5'b00000);

        reset = 1'b0;
        steps(2);
        check_all("idle_no_pg", 5'b00000);

        // Power-up: SETTLE on the edge that samples pwrgood, INIT 500 edges later.
        cptra_pwrgood = 1'b1;
        step();
        check_all("settle_entry", 5'b10001);
        steps(INIT_DELAY - 1);
        check("settle_last.init", pwr_caliptra_ss_lc_i.caliptra_ss_lc_init, 1'b0);
        step();
        check_all("init_entry", 5'b11001);

        steps(20);
        check_all("init_wait", 5'b11001);
        pulse_reinit();
        check_all("init_reinit_dropped", 5'b11001);

        pwr_caliptra_ss_lc_o.caliptra_ss_lc_done = 1'b1;
        step();
        pwr_caliptra_ss_lc_o.caliptra_ss_lc_done = 1'b0;
        check_all("done", 5'b11100);
        steps(3);
        check_all("done_hold", 5'b11100);

        // Re-init: reset low for exactly RST_HOLD cycles, init low meanwhile.
        pulse_reinit();
        check_all("rsthold_entry", 5'b00001);
        steps(RST_HOLD - 1);
        check_all("rsthold_last", 5'b00001);
        step();
        check_all("resettle_entry", 5'b10001);
        pulse_reinit();
        check_all("settle_reinit_dropped", 5'b10001);
        steps(INIT_DELAY - 2);
        check("resettle_last.init", pwr_caliptra_ss_lc_i.caliptra_ss_lc_init, 1'b0);
        step();
        check_all("reinit_init", 5'b11001);

        // Power-good drop in INIT with a coincident re-init request.
        cptra_pwrgood = 1'b0;
        reinit_req_i = 1'b1;
        step();
        reinit_req_i = 1'b0;
        check_all("pgdrop_init", 5'b00000);

        // Power-good drop in RSTHOLD with a coincident re-init request.
        cptra_pwrgood = 1'b1;
        steps(INIT_DELAY + 1);
        check_all("pg2_init", 5'b11001);
        pwr_caliptra_ss_lc_o.caliptra_ss_lc_done = 1'b1;
        step();
        pwr_caliptra_ss_lc_o.caliptra_ss_lc_done = 1'b0;
        pulse_reinit();
        check_all("pg2_rsthold", 5'b00001);
        steps(5);
        cptra_pwrgood = 1'b0;
        reinit_req_i = 1'b1;
        step();
        reinit_req_i = 1'b0;
        check_all("pgdrop_rsthold", 5'b00000);

        cptra_pwrgood = 1'b1;
        steps(INIT_DELAY + 1);
        check_all("to_init", 5'b11001);
`ifdef CALIPTRA_SS_LC_PWR_SEQ_TIMEOUT_EN
        steps(DONE_TIMEOUT - 1);
        check_all("to_before", 5'b11001);
        step();
        check_all("to_err", 5'b11010);
        pulse_reinit();
        check_all("err_reinit", 5'b00001);
`else
        steps(DONE_TIMEOUT + 100);
        check_all("no_timeout", 5'b11001);
`endif
        cptra_pwrgood = 1'b0;
        step();
        check_all("to_idle", 5'b00000);

        // Async reset between edges in SETTLE.
        cptra_pwrgood = 1'b1;
        steps(11);
        check_all("pre_async", 5'b10001);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 5'b00000);
        step();
        reset = 1'b0;
        check_all("post_release", 5'b00000);
        step();
        check_all("restart_settle", 5'b10001);
        steps(INIT_DELAY - 1);
        check("restart_last.init", pwr_caliptra_ss_lc_i.caliptra_ss_lc_init, 1'b0);
        step();
        check_all("restart_init", 5'b11001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/caliptra_ss_lc_pwr_seq.md
# caliptra_ss_lc_pwr_seq

Power-manager sequencer for the lifecycle controller: issues the LC initialization request to `caliptra_ss_lc_ctrl` and drives its local reset. It sits upstream of the LC controller on the `pwr_caliptra_ss_lc_i` / `pwr_caliptra_ss_lc_o` pair. On power-good it waits a settle delay, raises `caliptra_ss_lc_init`, and tracks `caliptra_ss_lc_done`. On a re-init request it pulses the LC reset and repeats the sequence. It replaces ad-hoc counter/indication logic with a defined FSM plus status outputs.

## Interface
Parameters:
- `INIT_DELAY`, 500: cycles from power-good (or end of reset pulse) to `caliptra_ss_lc_init` assertion; must be ≥1.
- `RST_HOLD`, 20: cycles `lc_rst_n_o` is held low on re-init; must be ≥1.
- `DONE_TIMEOUT`, 4096: maximum cycles in INIT waiting for `caliptra_ss_lc_done`; used only with the timeout feature.

Ports:
- `clk`  in  1  block clock. One clock only.
- `reset`  in  1  asynchronous, active-high reset.
- `cptra_pwrgood`  in  1  power-good; level-sensitive.
- `reinit_req_i`  in  1  single-cycle re-initialization request.
- `pwr_caliptra_ss_lc_i`  out  `pwrmgr_pkg::pwr_caliptra_ss_lc_req_t`  LC request; only `caliptra_ss_lc_init` is driven, all other bits 0.
- `pwr_caliptra_ss_lc_o`  in  `pwrmgr_pkg::pwr_caliptra_ss_lc_rsp_t`  LC response; `caliptra_ss_lc_done` is used.
- `lc_rst_n_o`  out  1  active-low reset to the LC controller.
- `init_done_o`  out  1  high while in DONE.
- `init_err_o`  out  1  high while in ERR.
- `busy_o`  out  1  high in SETTLE, INIT and RSTHOLD.

## Operation
FSM states: IDLE, SETTLE, INIT, DONE, RSTHOLD, ERR.
- **IDLE**
  - `lc_rst_n_o`=0, `caliptra_ss_lc_init`=0.
  - When `cptra_pwrgood`=1: go to SETTLE and load the counter with 0.
- **SETTLE**
  - `lc_rst_n_o`=1; the counter increments.
  - When the counter reaches `INIT_DELAY-1`: go to INIT and clear the counter.
- **INIT**
  - `caliptra_ss_lc_init`=1.
  - When `caliptra_ss_lc_done`=1: go to DONE.
  - With the timeout feature, if the counter reaches `DONE_TIMEOUT-1` first: go to ERR.
- **DONE**
  - `caliptra_ss_lc_init` stays 1 (level, per pwrmgr protocol).
  - `reinit_req_i`=1 goes to RSTHOLD.
- **RSTHOLD**
  - `lc_rst_n_o`=0, `caliptra_ss_lc_init`=0; the counter increments.
  - When the counter reaches `RST_HOLD-1`: go to SETTLE with the counter cleared.
- **ERR**
  - `caliptra_ss_lc_init`=1, `lc_rst_n_o`=1; the state is held.
  - `reinit_req_i` goes to RSTHOLD.
- **Power-good loss:** `cptra_pwrgood`=0 in any state except IDLE goes to IDLE on the next edge and overrides every other transition.
- **Dropped requests:** `reinit_req_i` in IDLE, SETTLE, INIT or RSTHOLD is dropped, not queued.
- **Simultaneous events:**
  - `caliptra_ss_lc_done` and timeout in the same cycle: done wins.
  - `reinit_req_i` and `cptra_pwrgood` falling in the same cycle: IDLE wins.
- **Counter:** one shared counter, width `$clog2(max(INIT_DELAY,RST_HOLD,DONE_TIMEOUT))+1`. It is cleared on every state change and never wraps, because each compare terminates it.

## Timing
- **Reset values:** state IDLE, counter 0, `lc_rst_n_o`=0, `caliptra_ss_lc_init`=0, `init_done_o`=0, `init_err_o`=0, `busy_o`=0.
- **Registered outputs:** all outputs are registered and decoded from the state, so they change one edge after the transition condition is sampled.
- **Power-good to init:** with `cptra_pwrgood` rising at edge N, SETTLE is entered at N+1 and `caliptra_ss_lc_init` rises at edge N+1+`INIT_DELAY`.
- **Done to status:** `caliptra_ss_lc_done` sampled high at edge M gives `init_done_o`=1 after edge M.
- **Re-init from DONE:** `reinit_req_i` at edge R gives `lc_rst_n_o` low for exactly `RST_HOLD` cycles (edges R+1 … R+`RST_HOLD`). It returns high entering SETTLE, and init rises `INIT_DELAY` cycles later.
- **Reset mid-sequence:** `reset` asserted mid-operation forces the reset values immediately, asynchronously.

## Configuration
- **`CALIPTRA_SS_LC_PWR_SEQ_TIMEOUT_EN` defined:** the INIT timeout is active and ERR is reachable.
- **Macro undefined:**
  - INIT waits indefinitely for `caliptra_ss_lc_done`.
  - ERR is unreachable and `init_err_o` is tied to 0.
  - `DONE_TIMEOUT` is ignored and does not contribute to the counter width.

## Test plan
- **Power-up:** `INIT_DELAY`=500; release `reset`, raise `cptra_pwrgood` at cycle 10 → `lc_rst_n_o`=1 at cycle 11, `caliptra_ss_lc_init`=1 at cycle 511, `busy_o`=1 for cycles 11–511+.
- **Done handshake:** drive `caliptra_ss_lc_done`=1 at 20 cycles after init → `init_done_o`=1 the next cycle, `busy_o`=0, init stays 1.
- **Re-init:** `RST_HOLD`=20; pulse `reinit_req_i` in DONE → `lc_rst_n_o`=0 for exactly 20 cycles, init=0 in that window, init re-asserts 500 cycles after `lc_rst_n_o` rises. A second pulse during SETTLE has no effect.
- **Timeout (macro on):** `DONE_TIMEOUT`=64, never drive done → `init_err_o`=1 at cycle 64 of INIT. Then `reinit_req_i` → RSTHOLD with `init_err_o`=0.
- **Power-good drop:** drop `cptra_pwrgood` in INIT and again in RSTHOLD, each time with a simultaneous `reinit_req_i` → next cycle IDLE, `lc_rst_n_o`=0, init=0, all status 0.
- **Async reset:** assert `reset` mid-SETTLE between clock edges → outputs take reset values without a clock edge. After release, the sequence restarts from IDLE.
